// File: rtl/load_store_unit.sv
// load_store_unit: drives a single-port word memory for one load/store at a time.
// Supports B/H/W loads with sign or zero extension, SW as a direct write, and
// SB/SH as a read-modify-write on the containing word.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   in_*               operation presented by the pipeline (accepted only in IDLE)
//   out_busy/out_done  stall indication and one-cycle completion pulse
//   out_rdata/error    load result and error flag, valid with out_done
//   mem_*              word-aligned request/grant/response memory port
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_read,
  input  logic        in_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_busy,
  output logic        out_done,
  output logic [31:0] out_rdata,
  output logic        out_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // Counter only needs to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    funct3_q, funct3_d;
  // Holds store data; for SB/SH it is overwritten with the merged word.
  logic [31:0]   wdata_q, wdata_d;
  logic          store_q, store_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          error_q, error_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic        accept_err;
  logic        bad_code;
  logic        misaligned;
  logic        tmo_hit;
  logic [31:0] rd_shift;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    case (in_funct3)
      3'b000, 3'b001, 3'b010: bad_code = 1'b0;
      3'b100, 3'b101:         bad_code = in_write;  // no unsigned stores
      default:                bad_code = 1'b1;
    endcase
    misaligned = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                 ((in_funct3 == 3'b010) && (in_addr[1:0] != 2'b00));
    accept_err = bad_code || misaligned || (in_read == in_write);
  end

  always_comb begin
    rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_val = {24'h000000, rd_shift[7:0]};
      3'b101:  load_val = {16'h0000, rd_shift[15:0]};
      default: load_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (funct3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else             merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  assign tmo_hit = (tmo_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    store_d  = store_q;
    rdata_d  = rdata_q;
    error_d  = error_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          addr_d   = in_addr;
          funct3_d = in_funct3;
          wdata_d  = in_wdata;
          store_d  = in_write;
          rdata_d  = '0;
          error_d  = accept_err;
          if (accept_err)                            state_d = DONE;
          else if (in_write && in_funct3 == 3'b010) state_d = WR_REQ;
          else                                       state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (mem_gnt) state_d = RD_WAIT;
        else if (tmo_hit) begin
          state_d = DONE;
          error_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          if (store_q) begin
            wdata_d = merged;
            state_d = WR_REQ;
          end else begin
            rdata_d = load_val;
            state_d = DONE;
          end
        end else if (tmo_hit) begin
          state_d = DONE;
          error_d = 1'b1;
        end
      end
      WR_REQ: begin
        if (mem_gnt) state_d = DONE;
        else if (tmo_hit) begin
          state_d = DONE;
          error_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) tmo_d = '0;
    else if (state_q == RD_REQ || state_q == RD_WAIT || state_q == WR_REQ)
      tmo_d = tmo_q + 1'b1;
    else tmo_d = tmo_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      store_q  <= 1'b0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      store_q  <= store_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
      tmo_q    <= tmo_d;
    end
  end

  assign out_busy  = (state_q != IDLE);
  assign out_done  = (state_q == DONE);
  assign out_rdata = rdata_q;
  assign out_error = error_q;
  assign mem_req   = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem_we    = (state_q == WR_REQ);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_read, in_write;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        out_busy, out_done, out_error;
  logic [31:0] out_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_read(in_read), .in_write(in_write),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_busy(out_busy), .out_done(out_done), .out_rdata(out_rdata), .out_error(out_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, memrd;
    int          gd, rvd;       // grant / rvalid delay in cycles (99 = never)
    bit          hold;          // keep in_valid high for the whole operation
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat, e_reqs;
    logic [31:0] e_maddr;
    logic        e_wr;
    logic [31:0] e_wdata;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] memrd,
      input int gd, input int rvd, input bit hold, input logic [31:0] e_rdata,
      input logic e_err, input int e_lat, input int e_reqs, input logic [31:0] e_maddr,
      input logic e_wr, input logic [31:0] e_wdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.memrd = memrd;
    v.gd = gd; v.rvd = rvd; v.hold = hold; v.e_rdata = e_rdata; v.e_err = e_err;
    v.e_lat = e_lat; v.e_reqs = e_reqs; v.e_maddr = e_maddr; v.e_wr = e_wr; v.e_wdata = e_wdata;
    return v;
  endfunction

  // Drives one operation and plays the memory; expected results go through the scoreboard.
  task automatic do_op(input vec_t v, input string tag);
    int lat = 0, reqs = 0, req_wait = 0, rv_wait = 0, stable_err = 0;
    bit rd_pending = 0, wr_seen = 0, got_done = 0, prev_req = 0;
    logic [31:0] maddr_seen = '0, wr_data = '0, prev_addr = '0, prev_wdata = '0;
    vec_t e;
    @(negedge clk);
    in_valid = 1'b1; in_read = v.rd; in_write = v.wr; in_funct3 = v.f3;
    in_addr = v.addr; in_wdata = v.wdata; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    sb_q.push_back(v);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!v.hold) in_valid = 1'b0;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (out_done) begin
        lat = c;
        got_done = 1;
        break;
      end
      if (rd_pending) begin
        if (rv_wait >= v.rvd) begin
          mem_rvalid = 1'b1; mem_rdata = v.memrd; rd_pending = 0;
        end else rv_wait++;
      end
      if (mem_req) begin
        reqs++;
        if (prev_req && (mem_addr !== prev_addr || (mem_we && mem_wdata !== prev_wdata)))
          stable_err++;
        prev_req = 1; prev_addr = mem_addr; prev_wdata = mem_wdata; maddr_seen = mem_addr;
        if (req_wait >= v.gd) begin
          mem_gnt = 1'b1; req_wait = 0; prev_req = 0;
          if (mem_we) begin
            wr_seen = 1; wr_data = mem_wdata;
          end else rd_pending = 1;
        end else req_wait++;
      end
    end
    in_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;

    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, " done"}, 32'(got_done), 32'd1);
    if (got_done) begin
      chk({tag, " latency"}, lat, e.e_lat);
      chk({tag, " error"}, 32'(out_error), 32'(e.e_err));
      chk({tag, " rdata"}, out_rdata, e.e_rdata);
    end
    chk({tag, " req_cycles"}, reqs, e.e_reqs);
    if (e.e_reqs > 0) chk({tag, " mem_addr"}, maddr_seen, e.e_maddr);
    chk({tag, " write_seen"}, 32'(wr_seen), 32'(e.e_wr));
    if (e.e_wr) chk({tag, " mem_wdata"}, wr_data, e.e_wdata);
    chk({tag, " stable"}, stable_err, 0);
    @(negedge clk);
    chk({tag, " idle_after"}, {30'd0, out_done, out_busy}, 32'd0);
  endtask

  initial begin
    int ab_done = 0, ab_busy = 0;
    reset = 1'b1; in_valid = 0; in_read = 0; in_write = 0; in_funct3 = '0;
    in_addr = '0; in_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;

    //      rd wr f3      addr         wdata         memrd        gd rvd h  e_rdata       err lat reqs maddr       wr e_wdata
    vecs.push_back(mk(1,0,3'b100,32'h103,32'h0,       32'h80FF1234, 0, 0,0, 32'h00000080, 0, 3, 1, 32'h100, 0, 32'h0));
    vecs.push_back(mk(1,0,3'b000,32'h103,32'h0,       32'h80FF1234, 0, 0,0, 32'hFFFFFF80, 0, 3, 1, 32'h100, 0, 32'h0));
    vecs.push_back(mk(1,0,3'b100,32'h101,32'h0,       32'h80FF1234, 0, 0,0, 32'h00000012, 0, 3, 1, 32'h100, 0, 32'h0));
    vecs.push_back(mk(1,0,3'b001,32'h202,32'h0,       32'h9ABC0000, 0, 0,0, 32'hFFFF9ABC, 0, 3, 1, 32'h200, 0, 32'h0));
    vecs.push_back(mk(1,0,3'b101,32'h202,32'h0,       32'h9ABC0000, 0, 0,0, 32'h00009ABC, 0, 3, 1, 32'h200, 0, 32'h0));
    vecs.push_back(mk(1,0,3'b010,32'h400,32'h0,       32'hDEADBEEF, 0, 0,0, 32'hDEADBEEF, 0, 3, 1, 32'h400, 0, 32'h0));
    vecs.push_back(mk(1,0,3'b000,32'h500,32'h0,       32'h1234567F, 0, 0,0, 32'h0000007F, 0, 3, 1, 32'h500, 0, 32'h0));
    vecs.push_back(mk(1,0,3'b001,32'h600,32'h0,       32'h00018001, 0, 0,0, 32'hFFFF8001, 0, 3, 1, 32'h600, 0, 32'h0));
    vecs.push_back(mk(0,1,3'b000,32'h301,32'h55,      32'hAABBCCDD, 0, 0,0, 32'h0,        0, 4, 2, 32'h300, 1, 32'hAABB55DD));
    vecs.push_back(mk(0,1,3'b001,32'h702,32'h12345678,32'hAABBCCDD, 0, 0,0, 32'h0,        0, 4, 2, 32'h700, 1, 32'h5678CCDD));
    vecs.push_back(mk(0,1,3'b001,32'hD00,32'hFFFFBEEF,32'h11223344, 0, 0,0, 32'h0,        0, 4, 2, 32'hD00, 1, 32'h1122BEEF));
    vecs.push_back(mk(0,1,3'b000,32'h003,32'hAB,      32'h11223344, 0, 0,0, 32'h0,        0, 4, 2, 32'h000, 1, 32'hAB223344));
    vecs.push_back(mk(0,1,3'b010,32'h800,32'hCAFEF00D,32'h0,        0, 0,0, 32'h0,        0, 2, 1, 32'h800, 1, 32'hCAFEF00D));
    vecs.push_back(mk(0,1,3'b010,32'h402,32'h1,       32'h0,        0, 0,0, 32'h0,        1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(1,0,3'b010,32'h001,32'h0,       32'h0,        0, 0,0, 32'h0,        1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(1,0,3'b001,32'h203,32'h0,       32'h0,        0, 0,0, 32'h0,        1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(1,0,3'b011,32'h000,32'h0,       32'h0,        0, 0,0, 32'h0,        1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(1,1,3'b010,32'h000,32'h0,       32'h0,        0, 0,0, 32'h0,        1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0,0,3'b010,32'h000,32'h0,       32'h0,        0, 0,0, 32'h0,        1, 1, 0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(1,0,3'b010,32'h404,32'h0,       32'h13579BDF, 0, 0,1, 32'h13579BDF, 0, 3, 1, 32'h404, 0, 32'h0));
    vecs.push_back(mk(1,0,3'b010,32'hB04,32'h0,       32'h01020304, 2, 1,0, 32'h01020304, 0, 6, 3, 32'hB04, 0, 32'h0));
    vecs.push_back(mk(0,1,3'b000,32'hC02,32'h77,      32'h00000000, 1, 0,0, 32'h0,        0, 6, 4, 32'hC00, 1, 32'h00770000));
    vecs.push_back(mk(1,0,3'b010,32'h900,32'h0,       32'h0,       99, 0,0, 32'h0,        1, 5, 4, 32'h900, 0, 32'h0));
    vecs.push_back(mk(1,0,3'b010,32'h908,32'h0,       32'h0,        0,99,0, 32'h0,        1, 6, 1, 32'h908, 0, 32'h0));
    vecs.push_back(mk(0,1,3'b010,32'h90C,32'h5,       32'h0,       99, 0,0, 32'h0,        1, 5, 4, 32'h90C, 0, 32'h0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy/done/err/req", {28'd0, out_busy, out_done, out_error, mem_req}, 32'd0);
    chk("reset out_rdata", out_rdata, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) do_op(vecs[i], $sformatf("v%0d", i));

    // Abort a load in RD_WAIT, then send stray rvalid pulses.
    @(negedge clk);
    in_valid = 1; in_read = 1; in_write = 0; in_funct3 = 3'b010; in_addr = 32'hA00;
    @(negedge clk);
    in_valid = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("abort in_rd_wait", {30'd0, out_busy, mem_req}, 32'd2);
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 4; c++) begin
      mem_rvalid = 1; mem_rdata = 32'h12345678;
      @(negedge clk);
      if (out_done) ab_done++;
      if (out_busy || mem_req) ab_busy++;
    end
    mem_rvalid = 0;
    chk("abort no_done", ab_done, 0);
    chk("abort idle", ab_busy, 0);
    do_op(mk(0,1,3'b010,32'hE00,32'h600DF00D,32'h0,0,0,0,32'h0,0,2,1,32'hE00,1,32'h600DF00D), "post_reset_sw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
